// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, FSM state type and parity helper for mem_rw_ctrl.
//   MEM_DATA_W / MEM_ADDR_W / MEM_DEPTH / MEM_RD_LAT : default parameter values
//   MEM_PAR_MAX_W : widest word the parity helper accepts (zero-extend narrower words)
//   mem_state_t   : INIT / RUN controller states
//   even_parity() : even-parity bit of a word (XOR reduction)
package mem_pkg;

  localparam int MEM_DATA_W    = 16;
  localparam int MEM_ADDR_W    = 4;
  localparam int MEM_DEPTH     = 16;
  localparam int MEM_RD_LAT    = 1;
  localparam int MEM_PAR_MAX_W = 256;

  typedef enum logic {INIT, RUN} mem_state_t;

  // Zero-extension does not change the XOR, so callers cast up to MEM_PAR_MAX_W.
  function automatic logic even_parity(input logic [MEM_PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: RD_LAT-deep shift register carrying read valid/data/error from
// request acceptance to the response outputs. reset_i flushes every stage.
//   clk_i, reset_i          : clock, synchronous active-high flush/reset
//   valid_i, data_i, err_i  : read accepted this cycle, its data and error flag
//   valid_o, data_o, err_o  : response, RD_LAT cycles after acceptance
module mem_rd_pipe #(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              err_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] err_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= valid_i;
      err_q[0] <= err_i;
      dat_q[0] <= data_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[RD_LAT-1];
  assign err_o   = err_q[RD_LAT-1];
  assign data_o  = dat_q[RD_LAT-1];

endmodule

// File: rtl/mem_rw_ctrl.sv
// mem_rw_ctrl: single-port synchronous memory with valid/ready requests, byte
// strobes, pipelined reads (RD_LAT), range checking and a post-reset clear.
// Optional feature macro: MEM_PARITY_EN (per-word even parity, inj_perr port).
//   clk, reset             : clock, synchronous active-high reset
//   req_valid / req_ready  : request handshake (ready only in RUN)
//   wr_en, rd_en, addr     : request type and word address
//   wdata, wstrb           : write data and byte enables
//   rsp_valid, rdata, rsp_err : read response, RD_LAT cycles after acceptance
//   init_done              : clear sequence finished
//   inj_perr (MEM_PARITY_EN only) : invert stored parity on accepted writes
//
// state | meaning
// ------+-----------------------------------------------------------------
// INIT  | after reset; zero-fills word[cnt] per cycle (INIT_CLEAR=1), no requests
// RUN   | req_ready=1, init_done=1 until the next reset
module mem_rw_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W     = MEM_DATA_W,
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DEPTH      = MEM_DEPTH,
  parameter int RD_LAT     = MEM_RD_LAT,
  parameter int INIT_CLEAR = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rdata,
  output logic                rsp_err,
  output logic                init_done
`ifdef MEM_PARITY_EN
  ,
  input  logic                inj_perr
`endif
);

  localparam int                NB       = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  mem_state_t        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              req_ready_q;
  logic              init_done_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              addr_oor;
  logic              wr_acc;
  logic              rd_acc;
  logic              clr_en;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word_d;
  logic              rd_rsp_err;

  // Gating with reset keeps a request presented during a reset cycle from
  // touching the memory while req_ready_q has not yet dropped.
  assign accept   = req_valid && req_ready_q && !reset;
  assign addr_oor = ({1'b0, addr} >= DEPTH_L);
  assign wr_acc   = accept && wr_en && !addr_oor;
  assign rd_acc   = accept && rd_en;
  assign clr_en   = (INIT_CLEAR != 0) && (state_q == INIT) && !reset;

  // Combinational read of the current contents: a same-cycle write lands at
  // the edge, so a read+write returns pre-write data and the next read sees it.
  assign rd_word = addr_oor ? '0 : mem_q[addr];

  always_comb begin
    wr_word_d = rd_word;
    for (int b = 0; b < NB; b++) begin
      if (wstrb[b]) wr_word_d[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if ((INIT_CLEAR == 0) || (cnt_q == CNT_LAST)) begin
            state_q     <= RUN;
            req_ready_q <= 1'b1;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          req_ready_q <= 1'b1;
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= INIT;
          req_ready_q <= 1'b0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Contents are deliberately not reset; only the INIT clear zeroes them.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc) begin
      mem_q[addr] <= wr_word_d;
    end
  end

`ifdef MEM_PARITY_EN
  logic par_q [DEPTH];
  logic par_d;

  assign par_d      = even_parity(MEM_PAR_MAX_W'(wr_word_d)) ^ inj_perr;
  assign rd_rsp_err = addr_oor ||
                      (even_parity(MEM_PAR_MAX_W'(rd_word)) != par_q[addr]);

  always_ff @(posedge clk) begin
    if (clr_en) begin
      par_q[cnt_q] <= 1'b0;
    end else if (wr_acc) begin
      par_q[addr] <= par_d;
    end
  end
`else
  assign rd_rsp_err = addr_oor;
`endif

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk_i   (clk),
    .reset_i (reset),
    .valid_i (rd_acc),
    .data_i  (rd_word),
    .err_i   (rd_rsp_err),
    .valid_o (rsp_valid),
    .data_o  (rdata),
    .err_o   (rsp_err)
  );

  assign req_ready = req_ready_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_mem_rw_ctrl.sv
// tb_mem_rw_ctrl: scoreboard bench for mem_rw_ctrl (DEPTH=12, RD_LAT=2).
// Expected responses come from a bench-side word/parity model and are queued
// at acceptance; a negedge monitor pops and compares data, error and latency.
module tb_mem_rw_ctrl;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int DEP = 12;
  localparam int LAT = 2;
  localparam int NB  = DW / 8;
`ifdef MEM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] wstrb = '0;
  logic          inj_perr = 1'b0;
  logic          req_ready;
  logic          rsp_valid;
  logic          rsp_err;
  logic          init_done;
  logic [DW-1:0] rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int rsp_count = 0;

  logic [DW-1:0] ref_mem [16];
  logic          ref_par [16];

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            acc_cyc;
  } exp_t;
  exp_t sb[$];
  int   rsp_cyc[$];

  mem_rw_ctrl #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .DEPTH      (DEP),
    .RD_LAT     (LAT),
    .INIT_CLEAR (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .addr      (addr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
`ifdef MEM_PARITY_EN
    ,
    .inj_perr  (inj_perr)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid === 1'b1) begin
        checks++;
        rsp_count++;
        rsp_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp cyc=%0d rdata=%h rsp_err=%b, expected no response",
                   cyc, rdata, rsp_err);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (rdata !== e.data || rsp_err !== e.err || (cyc - e.acc_cyc) != LAT) begin
            errors++;
            $display("FAIL rsp cyc=%0d got data=%h err=%b lat=%0d, expected data=%h err=%b lat=%0d",
                     cyc, rdata, rsp_err, cyc - e.acc_cyc, e.data, e.err, LAT);
          end
        end
      end else if (rsp_valid !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL rsp_valid_x cyc=%0d got %b, expected 0/1", cyc, rsp_valid);
      end else if (sb.size() > 0 && (cyc - sb[0].acc_cyc) >= LAT) begin
        exp_t e;
        checks++;
        errors++;
        e = sb.pop_front();
        $display("FAIL missing_rsp cyc=%0d got rsp_valid=0, expected data=%h err=%b",
                 cyc, e.data, e.err);
      end
    end
  end

  task automatic idle(input int n);
    req_valid = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    wstrb     = '0;
    inj_perr  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one request for one cycle and updates the model on acceptance.
  task automatic do_req(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [NB-1:0] s);
    exp_t          e;
    logic [DW-1:0] m;
    logic          oor;
    req_valid = 1'b1;
    rd_en     = rd;
    wr_en     = wr;
    addr      = a;
    wdata     = d;
    wstrb     = s;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_run got %b, expected 1", req_ready);
    end else begin
      oor = (int'(a) >= DEP);
      if (rd) begin
        e.data    = oor ? '0 : ref_mem[a];
        e.err     = oor | (PAR_EN & !oor & ((^ref_mem[a]) != ref_par[a]));
        e.acc_cyc = cyc;
        sb.push_back(e);
      end
      if (wr && !oor) begin
        m = ref_mem[a];
        for (int b = 0; b < NB; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
        ref_mem[a] = m;
        ref_par[a] = (^m) ^ inj_perr;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_%s got %0d pending responses, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Holds reset, checks reset values, then times the INIT clear sequence.
  task automatic apply_reset();
    int bad;
    reset     = 1'b1;
    req_valid = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    repeat (3) @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
        init_done !== 1'b0 || rdata !== '0) begin
      errors++;
      $display("FAIL reset_values got ready=%b rv=%b err=%b done=%b rdata=%h, expected all 0",
               req_ready, rsp_valid, rsp_err, init_done, rdata);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = '0;
      ref_par[i] = 1'b0;
    end
    bad = 0;
    for (int i = 0; i < DEP; i++) begin
      @(negedge clk);
      if (req_ready !== 1'b0 || init_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL init_hold got %0d early-ready cycles, expected 0 of %0d", bad, DEP);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_end got ready=%b done=%b, expected 1 1", req_ready, init_done);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    do_req(1'b1, 1'b0, 4'd5, '0, '0);
    idle(1);
    wait_drain("reset_read");
  endtask

  task automatic test_strobe();
    do_req(1'b0, 1'b1, 4'd3, 16'hA5C3, 2'b11);
    do_req(1'b0, 1'b1, 4'd3, 16'h11FF, 2'b01);
    do_req(1'b1, 1'b0, 4'd3, '0, '0);
    do_req(1'b0, 1'b1, 4'd4, 16'hCAFE, 2'b10);
    do_req(1'b1, 1'b0, 4'd4, '0, '0);
    idle(1);
    wait_drain("strobe");
  endtask

  task automatic test_back_to_back();
    int n0;
    do_req(1'b0, 1'b1, 4'd0, 16'h0001, 2'b11);
    do_req(1'b0, 1'b1, 4'd1, 16'h0002, 2'b11);
    do_req(1'b0, 1'b1, 4'd2, 16'h0003, 2'b11);
    idle(1);
    n0 = rsp_cyc.size();
    do_req(1'b1, 1'b0, 4'd0, '0, '0);
    do_req(1'b1, 1'b0, 4'd1, '0, '0);
    do_req(1'b1, 1'b0, 4'd2, '0, '0);
    idle(1);
    wait_drain("b2b");
    checks++;
    if (rsp_cyc.size() != n0 + 3 ||
        rsp_cyc[n0+1] != rsp_cyc[n0] + 1 || rsp_cyc[n0+2] != rsp_cyc[n0] + 2) begin
      errors++;
      $display("FAIL b2b_spacing got %0d responses, expected 3 on consecutive cycles",
               rsp_cyc.size() - n0);
    end
  endtask

  task automatic test_rbw();
    do_req(1'b0, 1'b1, 4'd7, 16'h1234, 2'b11);
    do_req(1'b1, 1'b1, 4'd7, 16'hBEEF, 2'b11);
    do_req(1'b1, 1'b0, 4'd7, '0, '0);
    idle(1);
    wait_drain("rbw");
  endtask

  task automatic test_oor();
    do_req(1'b0, 1'b1, 4'd13, 16'hFFFF, 2'b11);
    do_req(1'b1, 1'b0, 4'd13, '0, '0);
    do_req(1'b0, 1'b1, 4'd12, 16'h5555, 2'b11);
    do_req(1'b0, 1'b1, 4'd11, 16'h7E57, 2'b11);
    do_req(1'b1, 1'b0, 4'd12, '0, '0);
    do_req(1'b1, 1'b0, 4'd11, '0, '0);
    for (int i = 0; i < 8; i++) do_req(1'b1, 1'b0, AW'(i), '0, '0);
    idle(1);
    wait_drain("oor");
  endtask

  task automatic test_noop_strobe0();
    do_req(1'b0, 1'b1, 4'd7, 16'h0000, 2'b00);
    do_req(1'b0, 1'b0, 4'd7, 16'h0000, 2'b11);
    do_req(1'b1, 1'b0, 4'd7, '0, '0);
    idle(3);
    wait_drain("noop");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             AW'($urandom_range(0, 15)), DW'($urandom), NB'($urandom));
    end
    idle(1);
    wait_drain("random");
  endtask

  task automatic test_mid_reset();
    int n0;
    do_req(1'b0, 1'b1, 4'd3, 16'h3C3C, 2'b11);
    n0 = rsp_count;
    do_req(1'b1, 1'b0, 4'd3, '0, '0);
    reset     = 1'b1;
    req_valid = 1'b0;
    rd_en     = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    apply_reset();
    checks++;
    if (rsp_count != n0) begin
      errors++;
      $display("FAIL mid_reset_flush got %0d responses, expected 0", rsp_count - n0);
    end
    do_req(1'b1, 1'b0, 4'd3, '0, '0);
    idle(1);
    wait_drain("mid_reset");
  endtask

  task automatic test_parity();
    inj_perr = 1'b1;
    do_req(1'b0, 1'b1, 4'd9, 16'h00FF, 2'b11);
    inj_perr = 1'b0;
    do_req(1'b1, 1'b0, 4'd9, '0, '0);
    do_req(1'b0, 1'b1, 4'd9, 16'h00FE, 2'b01);
    do_req(1'b1, 1'b0, 4'd9, '0, '0);
    idle(1);
    wait_drain("parity");
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_back_to_back();
    test_rbw();
    test_oor();
    test_noop_strobe0();
    test_random();
    test_mid_reset();
    if (PAR_EN) test_parity();
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_rw_ctrl.md
Name: mem_rw_ctrl

Overview:
- Parametrised single-port synchronous memory. Supersedes the fixed 16-word x 16-bit memory driven over the rd_en/wr_en/addr/wdata/rdata bus.
- Adds a valid/ready request handshake, byte write strobes, a configurable pipelined read latency, range checking and a post-reset clear sequence.
- Sits as the DUT behind the driver/monitor interface. The interface is widened to match the parameters.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 4, address width in bits.
- DEPTH, 16, number of words; 1 <= DEPTH <= 2**ADDR_W.
- RD_LAT, 1, read latency in cycles from request acceptance to response; legal range 1..4.
- INIT_CLEAR, 1, when 1 the memory is zero-filled after reset; when 0 it is not.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- wr_en  input  1  write request; qualified by req_valid.
- rd_en  input  1  read request; qualified by req_valid.
- addr  input  ADDR_W  word address.
- wdata  input  DATA_W  write data.
- wstrb  input  DATA_W/8  byte write enables; bit i covers wdata[8i+7:8i].
- rsp_valid  output  1  read response valid, single-cycle pulse per read.
- rdata  output  DATA_W  read data, meaningful only while rsp_valid=1.
- rsp_err  output  1  response error; valid only while rsp_valid=1.
- init_done  output  1  high once the clear sequence has finished.

Behaviour:
- Decided: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: req_ready=0, rsp_valid=0, rdata=0, rsp_err=0, init_done=0. FSM goes to INIT and the clear counter goes to 0.
- FSM states are INIT and RUN.
  - INIT with INIT_CLEAR=1: writes 0 to word[cnt] each cycle for DEPTH cycles, then moves to RUN.
  - INIT with INIT_CLEAR=0: moves to RUN on the first cycle after reset deasserts.
  - RUN: req_ready=1 and init_done=1. Both remain high until the next reset.
- A request is accepted on a cycle where req_valid && req_ready. Requests are never accepted in INIT.
- Write: on acceptance with wr_en=1, bytes whose wstrb bit is 1 are updated at that clock edge. wstrb=0 means no change.
- Read: on acceptance with rd_en=1, rsp_valid pulses exactly RD_LAT cycles later, carrying rdata and rsp_err.
  - Reads are fully pipelined: one response per accepted read, in order, with no bubbles.
  - There is no response backpressure.
- rd_en and wr_en both high: read-before-write. The response returns the pre-write data, and the write is still performed.
- Accepted request with rd_en=wr_en=0: no effect and no response.
- A read accepted in the cycle after a write to the same address returns the newly written data.
- Out-of-range address (addr >= DEPTH):
  - Write is dropped.
  - Read returns rdata=0 with rsp_err=1.
- Reset asserted mid-operation:
  - The read pipeline is flushed; rsp_valid=0 from the next cycle.
  - Memory contents change only through a new INIT clear.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - Each word stores an even-parity bit computed over the full word after the strobed merge.
  - Each read recomputes parity, and rsp_err is also set on a mismatch.
  - An extra input port inj_perr (1 bit) inverts the stored parity bit on a write accepted while inj_perr=1.
- Undefined: no parity storage and no inj_perr port. rsp_err reflects only range errors.

Decomposition:
- Package mem_pkg holds:
  - default constants MEM_DATA_W, MEM_ADDR_W, MEM_DEPTH, MEM_RD_LAT;
  - typedef enum logic {INIT, RUN} mem_state_t;
  - a function for even parity.
- One sub-module, mem_rd_pipe: an RD_LAT-deep valid/data/err shift register with synchronous flush on reset.

Test Plan (DATA_W=16, ADDR_W=4, DEPTH=12, RD_LAT=2, INIT_CLEAR=1 unless stated):
- Reset release -> req_ready=0 for 12 cycles, then req_ready=1 and init_done=1. A read of addr 5 returns 0x0000 two cycles after acceptance.
- Write 0xA5C3 to addr 3 with wstrb=2'b11, then write 0x11FF with wstrb=2'b01, then read addr 3 -> rdata=0xA5FF, rsp_err=0.
- Reads of addr 0,1,2 accepted on back-to-back cycles (preloaded 0x0001/0x0002/0x0003) -> rsp_valid high for three consecutive cycles with rdata 0x0001, 0x0002, 0x0003.
- rd_en=wr_en=1 on addr 7 (holding 0x1234) with wdata 0xBEEF -> response 0x1234; a following read of addr 7 returns 0xBEEF.
- Write 0xFFFF to addr 13 (out of range), then read addr 13 -> rdata=0x0000, rsp_err=1; word contents elsewhere unchanged.
- Reset asserted one cycle after a read is accepted -> no rsp_valid pulse; INIT restarts.
- With MEM_PARITY_EN defined: write 0x00FF with inj_perr=1, then read -> rsp_err=1, rdata=0x00FF.
